sr_button_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the gated SR latch. It takes two raw, asynchronous, bouncing push-button inputs (set and reset) and produces the latch's S, R and enable drives. Each button is synchronised and debounced, and a single-cycle command pulse is emitted on every debounced press. Simultaneous presses are suppressed, so the latch never sees S=R=1.

---
 rtl/sr_button_conditioner.sv | 128 ++++++++++++
 tb/tb_sr_button_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_button_conditioner.sv
// Synchronise, debounce and pulse-encode two push buttons feeding a gated SR latch.
// Press-to-pulse latency is DEBOUNCE_CYCLES+2 edges; simultaneous presses are flagged, never forwarded.
module sr_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic enable,
  output logic set_stable,
  output logic reset_stable,
  output logic conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, ARM_HI, PRESSED, ARM_LO} state_e;

  logic [1:0] btn;
  logic [1:0] press;
  logic [1:0] stable;

  assign btn = {btn_reset, btn_set};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, sync2_q;
    logic          stable_q;
    logic          press_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        state_q  <= IDLE;
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        sync1_q  <= btn[g];
        sync2_q  <= sync1_q;
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        stable_q <= (state_d == PRESSED) || (state_d == ARM_LO);
      end
    end

    // Counter tracks consecutive samples opposing the current stable level.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_d = ARM_HI;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ARM_HI: begin
          if (!sync2_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q) begin
            state_d = ARM_LO;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = '0;
          end
        end
        ARM_LO: begin
          if (sync2_q) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

    assign press[g]  = press_d;
    assign stable[g] = stable_q;
  end

  logic s_q, r_q, en_q, conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      en_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= press[0] & ~press[1];
      r_q        <= press[1] & ~press[0];
      en_q       <= press[0] ^ press[1];
      conflict_q <= press[0] & press[1];
    end
  end

  assign S            = s_q;
  assign R            = r_q;
  assign enable       = en_q;
  assign conflict     = conflict_q;
  assign set_stable   = stable[0];
  assign reset_stable = stable[1];

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Bench for sr_button_conditioner: directed scenarios plus random bouncing, checked against a sliding-window model.
module tb_sr_button_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_set = 1'b0;
  logic btn_reset = 1'b0;
  logic S, R, enable, set_stable, reset_stable, conflict;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  sr_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn_set(btn_set), .btn_reset(btn_reset),
    .S(S), .R(R), .enable(enable), .set_stable(set_stable),
    .reset_stable(reset_stable), .conflict(conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: a level is accepted once the last D samples seen past the
  // two-flop synchroniser all disagree with the current accepted level.
  bit hist[2][$];
  bit m_stable[2];
  logic [5:0] m_out = '0;  // {S,R,enable,conflict,set_stable,reset_stable}

  always @(posedge clk or posedge rst) begin
    bit pr[2];
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        hist[ch].delete();
        hist[ch].push_back(1'b0);
        hist[ch].push_back(1'b0);
        m_stable[ch] = 1'b0;
      end
      m_out = '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        bit all_flip;
        hist[ch].push_back(ch == 0 ? btn_set : btn_reset);
        if (hist[ch].size() > D + 2) void'(hist[ch].pop_front());
        pr[ch] = 1'b0;
        if (hist[ch].size() == D + 2) begin
          all_flip = 1'b1;
          for (int i = 0; i < D; i++)
            if (hist[ch][i] == m_stable[ch]) all_flip = 1'b0;
          if (all_flip) begin
            m_stable[ch] = !m_stable[ch];
            pr[ch] = m_stable[ch];
          end
        end
      end
      m_out = {pr[0] & !pr[1], pr[1] & !pr[0], pr[0] ^ pr[1], pr[0] & pr[1],
               m_stable[0], m_stable[1]};
    end
  end

  function automatic logic [5:0] outs();
    return {S, R, enable, conflict, set_stable, reset_stable};
  endfunction

  task automatic test_reset();
    int k, s_cnt, s_cyc;
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (outs() !== 6'b0) begin n_fail++; $display("FAIL reset_por got=%b exp=000000", outs()); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (outs() !== 6'b0) begin n_fail++; $display("FAIL idle_after_reset got=%b exp=000000", outs()); end
    btn_set = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (set_stable !== 1'b1) begin n_fail++; $display("FAIL held_before_reset got=%b exp=1", set_stable); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (outs() !== 6'b0) begin n_fail++; $display("FAIL reset_immediate got=%b exp=000000", outs()); end
    repeat (3) @(negedge clk);
    n_tests++;
    if (outs() !== 6'b0) begin n_fail++; $display("FAIL reset_held got=%b exp=000000", outs()); end
    rst = 1'b0;
    k = cyc + 1; s_cnt = 0; s_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (S) begin s_cnt++; s_cyc = cyc; end
    end
    n_tests++;
    if (s_cnt !== 1) begin n_fail++; $display("FAIL reset_repress_count got=%0d exp=1", s_cnt); end
    n_tests++;
    if (s_cyc !== k + 5) begin n_fail++; $display("FAIL reset_repress_edge got=%0d exp=%0d", s_cyc, k + 5); end
    btn_set = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int k, s_cnt, s_cyc, en_cnt, r_cnt, rise, fall;
    btn_set = 1'b1;
    k = cyc + 1; s_cnt = 0; s_cyc = -1; en_cnt = 0; r_cnt = 0; rise = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL press_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (S) begin s_cnt++; s_cyc = cyc; end
      if (enable) en_cnt++;
      if (R) r_cnt++;
      if (set_stable && rise < 0) rise = cyc;
    end
    n_tests++;
    if (s_cnt !== 1 || en_cnt !== 1) begin n_fail++; $display("FAIL press_pulse_count got S=%0d en=%0d exp 1/1", s_cnt, en_cnt); end
    n_tests++;
    if (s_cyc !== k + 5) begin n_fail++; $display("FAIL press_pulse_edge got=%0d exp=%0d", s_cyc, k + 5); end
    n_tests++;
    if (rise !== k + 5) begin n_fail++; $display("FAIL press_stable_edge got=%0d exp=%0d", rise, k + 5); end
    n_tests++;
    if (r_cnt !== 0) begin n_fail++; $display("FAIL press_no_r got=%0d exp=0", r_cnt); end
    btn_set = 1'b0;
    k = cyc + 1; s_cnt = 0; fall = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL release_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (S || R || enable) s_cnt++;
      if (!set_stable && fall < 0) fall = cyc;
    end
    n_tests++;
    if (fall !== k + 5) begin n_fail++; $display("FAIL release_stable_edge got=%0d exp=%0d", fall, k + 5); end
    n_tests++;
    if (s_cnt !== 0) begin n_fail++; $display("FAIL release_no_pulse got=%0d exp=0", s_cnt); end
  endtask

  task automatic test_bounce_reject();
    int seen;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 20 && i % 2 == 0) btn_reset = ~btn_reset;
      if (i == 20) btn_reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (reset_stable || R || enable) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL bounce_reject got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_bounce_settle();
    int k, s_cnt, s_cyc;
    s_cnt = 0; s_cyc = -1; k = -1;
    for (int i = 0; i < 18; i++) begin
      if (i == 0 || i == 4) btn_set = 1'b1;
      if (i == 2) btn_set = 1'b0;
      if (i == 4) k = cyc + 1;
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL settle_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (S) begin s_cnt++; s_cyc = cyc; end
    end
    n_tests++;
    if (s_cnt !== 1) begin n_fail++; $display("FAIL settle_count got=%0d exp=1", s_cnt); end
    n_tests++;
    if (s_cyc !== k + 5) begin n_fail++; $display("FAIL settle_edge got=%0d exp=%0d", s_cyc, k + 5); end
    btn_set = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int k, rs, rr, c_cnt, c_cyc, cmd;
    btn_set = 1'b1; btn_reset = 1'b1;
    k = cyc + 1; rs = -1; rr = -1; c_cnt = 0; c_cyc = -1; cmd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL simul_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (set_stable && rs < 0) rs = cyc;
      if (reset_stable && rr < 0) rr = cyc;
      if (conflict) begin c_cnt++; c_cyc = cyc; end
      if (S || R || enable) cmd++;
    end
    n_tests++;
    if (rs !== k + 5 || rr !== k + 5) begin n_fail++; $display("FAIL simul_stable_edges got=%0d/%0d exp=%0d", rs, rr, k + 5); end
    n_tests++;
    if (c_cnt !== 1 || c_cyc !== k + 5) begin n_fail++; $display("FAIL simul_conflict got cnt=%0d edge=%0d exp 1/%0d", c_cnt, c_cyc, k + 5); end
    n_tests++;
    if (cmd !== 0) begin n_fail++; $display("FAIL simul_no_cmd got=%0d exp=0", cmd); end
    btn_set = 1'b0; btn_reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_overlap();
    int k, r_cnt, r_cyc, s_cnt, c_cnt, en_cnt;
    btn_set = 1'b1;
    repeat (10) @(negedge clk);
    btn_reset = 1'b1;
    k = cyc + 1; r_cnt = 0; r_cyc = -1; s_cnt = 0; c_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL overlap_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
      if (R) begin r_cnt++; r_cyc = cyc; end
      if (S) s_cnt++;
      if (conflict) c_cnt++;
      if (enable) en_cnt++;
    end
    n_tests++;
    if (r_cnt !== 1 || r_cyc !== k + 5) begin n_fail++; $display("FAIL overlap_r got cnt=%0d edge=%0d exp 1/%0d", r_cnt, r_cyc, k + 5); end
    n_tests++;
    if (s_cnt !== 0 || c_cnt !== 0 || en_cnt !== 1) begin n_fail++; $display("FAIL overlap_other got S=%0d conf=%0d en=%0d exp 0/0/1", s_cnt, c_cnt, en_cnt); end
    btn_set = 1'b0; btn_reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int hold_s, hold_r;
    hold_s = 0; hold_r = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold_s == 0) begin btn_set = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 2 * D + 1); end
      if (hold_r == 0) begin btn_reset = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 2 * D + 1); end
      hold_s--; hold_r--;
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      n_tests++;
      if (outs() !== m_out) begin n_fail++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, outs(), m_out); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_bounce_settle();
    test_simultaneous();
    test_overlap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
